mips_multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the 32-bit MIPS datapath. It sequences the PC, instruction register, register file, ALU operand mux and data memory through FETCH/DECODE/EXEC/MEM/WB states, so one instruction executes at a time. This replaces the combinational per-opcode glue in the top level. It handles a ready handshake on data memory, detects illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/mips_multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle FSM sequencing the MIPS datapath.
// Optional macro SINGLE_STEP_EN adds a step input that gates IDLE -> FETCH.
module mips_multicycle_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             reset,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_b,
  output logic             mem_re,
  output logic             mem_we,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       state,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

`ifdef SINGLE_STEP_EN
  localparam state_t S_RET = S_IDLE;
`else
  localparam state_t S_RET = S_FETCH;
`endif

  state_t           st_q, st_d;
  logic [5:0]       op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ret_raw;
  logic             go;

  logic is_r, is_lw, is_sw, is_beq, is_j;
  logic dec_ok;

  assign is_r   = (op_q == OP_R);
  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);
  assign is_beq = (op_q == OP_BEQ);
  assign is_j   = (op_q == OP_J);

  assign dec_ok = (opcode == OP_R)  ||
                  (opcode == OP_LW) ||
                  (opcode == OP_SW) ||
                  (opcode == OP_BEQ) ||
                  (opcode == OP_J);

`ifdef SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  // A retire in the reset cycle is abandoned, so it never reaches the counter.
  assign retire    = ret_raw & ~reset;
  assign instr_cnt = cnt_q;
  assign state     = st_q;
  assign err       = err_q;

  // Next-state and strobe decode from state, latched opcode and zero.
  always_comb begin
    st_d       = st_q;
    op_d       = op_q;
    wait_d     = wait_q;
    err_d      = err_q;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ret_raw    = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (go) st_d = S_FETCH;
      end
      S_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
        st_d  = S_DECODE;
      end
      S_DECODE: begin
        op_d = opcode;
        if (dec_ok) begin
          st_d = S_EXEC;
        end else begin
          st_d  = S_HALT;
          err_d = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_b = is_lw | is_sw;
        unique case (1'b1)
          is_r: st_d = S_WB;
          is_lw, is_sw: begin
            st_d   = S_MEM;
            wait_d = 8'd0;
          end
          is_beq: begin
            pc_we   = zero;
            pc_src  = 2'b01;
            ret_raw = 1'b1;
            st_d    = S_RET;
          end
          is_j: begin
            pc_we   = 1'b1;
            pc_src  = 2'b10;
            ret_raw = 1'b1;
            st_d    = S_RET;
          end
          default: begin
            st_d  = S_HALT;
            err_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        alu_src_b = 1'b1;
        mem_re    = is_lw;
        mem_we    = is_sw;
        // Ready beats a timeout that lands in the same cycle.
        if (mem_ready) begin
          if (is_lw) begin
            st_d = S_WB;
          end else begin
            ret_raw = 1'b1;
            st_d    = S_RET;
          end
        end else if (wait_q == WAIT_LAST) begin
          st_d  = S_HALT;
          err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        ret_raw    = 1'b1;
        st_d       = S_RET;
      end
      S_HALT: st_d = S_HALT;
      default: st_d = S_IDLE;
    endcase
  end

  // State, latched opcode, wait counter, sticky error and retire counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      st_q   <= S_IDLE;
      op_q   <= 6'd0;
      wait_q <= 8'd0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      op_q   <= op_d;
      wait_q <= wait_d;
      err_q  <= err_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized self-checking bench for the control FSM.
// Expected per-cycle traces are built per instruction from its latency rules.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

  localparam int CW = 4;
  localparam int TO = 15;
  localparam int W  = CW + 15;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = 6'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
`ifdef SINGLE_STEP_EN
  logic          step = 1'b1;
`endif
  logic          pc_we, ir_we, reg_we, reg_dst, mem_to_reg;
  logic          alu_src_b, mem_re, mem_we, retire, err;
  logic [1:0]    pc_src;
  logic [CW-1:0] instr_cnt;
  logic [2:0]    state;

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .CLK(CLK),
    .reset(reset),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .opcode(opcode),
    .zero(zero),
    .mem_ready(mem_ready),
    .pc_we(pc_we),
    .pc_src(pc_src),
    .ir_we(ir_we),
    .reg_we(reg_we),
    .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b),
    .mem_re(mem_re),
    .mem_we(mem_we),
    .retire(retire),
    .instr_cnt(instr_cnt),
    .state(state),
    .err(err)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       reg_we;
    logic       reg_dst;
    logic       m2r;
    logic       asb;
    logic       mre;
    logic       mwe;
    logic       ret;
    logic       err;
  } exp_t;

  typedef struct {
    exp_t       e;
    logic [5:0] op;
    logic       rdy;
    logic       z;
    logic       rst;
    logic       stp;
  } cyc_t;

  cyc_t          q[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] cnt_m = '0;
  logic          err_m = 1'b0;
  bit            need_idle = 1'b1;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic exp_t blank(input logic [2:0] s);
    exp_t e;
    e     = '0;
    e.st  = s;
    e.err = err_m;
    return e;
  endfunction

  function automatic void push(input exp_t e, input logic [5:0] o,
                               input logic r, input logic z);
    cyc_t c;
    c.e   = e;
    c.op  = o;
    c.rdy = r;
    c.z   = z;
    c.rst = 1'b0;
    c.stp = 1'b1;
    q.push_back(c);
  endfunction

  // Expected trace of one instruction; w = MEM cycles before ready (>=TO: never).
  task automatic build(input logic [5:0] op, input logic z, input int w);
    exp_t e;
    if (need_idle) begin
      push(blank(3'd0), op, rb(), rb());
      need_idle = 1'b0;
    end
    e = blank(3'd1); e.pc_we = 1'b1; e.ir_we = 1'b1;
    push(e, op, rb(), rb());
    push(blank(3'd2), op, rb(), rb());
    if (op == OP_R) begin
      push(blank(3'd3), rop(), rb(), rb());
      e = blank(3'd5); e.reg_we = 1'b1; e.reg_dst = 1'b1; e.ret = 1'b1;
      push(e, rop(), rb(), rb());
    end else if (op == OP_BEQ || op == OP_J) begin
      e = blank(3'd3);
      e.pc_we  = (op == OP_J) ? 1'b1 : z;
      e.pc_src = (op == OP_J) ? 2'b10 : 2'b01;
      e.ret    = 1'b1;
      push(e, rop(), rb(), z);
    end else if (op == OP_LW || op == OP_SW) begin
      e = blank(3'd3); e.asb = 1'b1;
      push(e, rop(), rb(), rb());
      for (int k = 0; k < TO && k <= w; k++) begin
        e = blank(3'd4); e.asb = 1'b1;
        e.mre = (op == OP_LW);
        e.mwe = (op == OP_SW);
        e.ret = (op == OP_SW) && (k == w);
        push(e, rop(), (k == w), rb());
      end
      if (w >= TO) begin
        err_m = 1'b1;
      end else if (op == OP_LW) begin
        e = blank(3'd5); e.reg_we = 1'b1; e.m2r = 1'b1; e.ret = 1'b1;
        push(e, rop(), rb(), rb());
      end
    end else begin
      err_m = 1'b1;
    end
`ifdef SINGLE_STEP_EN
    need_idle = 1'b1;
`endif
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) push(blank(3'd7), rop(), rb(), rb());
  endtask

  // Drives one cycle from a trace entry; returns observed and expected vectors.
  task automatic cycle(input cyc_t c, output logic [W-1:0] obs,
                       output logic [W-1:0] ex);
    @(negedge CLK);
    opcode    = c.op;
    mem_ready = c.rdy;
    zero      = c.z;
    reset     = c.rst;
`ifdef SINGLE_STEP_EN
    step      = c.stp;
`endif
    #1;
    obs = {instr_cnt, state, pc_we, pc_src, ir_we, reg_we, reg_dst,
           mem_to_reg, alu_src_b, mem_re, mem_we, retire, err};
    ex  = {cnt_m, c.e};
    if (c.e.ret) cnt_m = cnt_m + 1'b1;
    if (c.rst) cnt_m = '0;
  endtask

  task automatic test_reset();
    logic [W-1:0] obs;
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = rop();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    obs = {instr_cnt, state, pc_we, pc_src, ir_we, reg_we, reg_dst,
           mem_to_reg, alu_src_b, mem_re, mem_we, retire, err};
    checks++;
    if (obs !== {W{1'b0}}) begin
      errors++;
      $display("FAIL reset got %h exp %h", obs, {W{1'b0}});
    end
    cnt_m     = '0;
    err_m     = 1'b0;
    need_idle = 1'b1;
  endtask

  task automatic test_rtype();
    cyc_t c; logic [W-1:0] obs, ex;
    build(OP_R, 1'b0, 0);
    while (q.size() > 0) begin
      c = q.pop_front(); cycle(c, obs, ex); checks++;
      if (obs !== ex) begin errors++; $display("FAIL rtype got %h exp %h", obs, ex); end
    end
  endtask

  task automatic test_lw();
    cyc_t c; logic [W-1:0] obs, ex;
    build(OP_LW, rb(), 3);
    build(OP_LW, rb(), 0);
    while (q.size() > 0) begin
      c = q.pop_front(); cycle(c, obs, ex); checks++;
      if (obs !== ex) begin errors++; $display("FAIL lw got %h exp %h", obs, ex); end
    end
  endtask

  task automatic test_beq();
    cyc_t c; logic [W-1:0] obs, ex;
    build(OP_BEQ, 1'b1, 0);
    build(OP_BEQ, 1'b0, 0);
    while (q.size() > 0) begin
      c = q.pop_front(); cycle(c, obs, ex); checks++;
      if (obs !== ex) begin errors++; $display("FAIL beq got %h exp %h", obs, ex); end
    end
  endtask

  task automatic test_j_illegal();
    cyc_t c; logic [W-1:0] obs, ex;
    build(OP_J, rb(), 0);
    build(6'b111111, rb(), 0);
    halt_cycles(20);
    while (q.size() > 0) begin
      c = q.pop_front(); cycle(c, obs, ex); checks++;
      if (obs !== ex) begin errors++; $display("FAIL j_illegal got %h exp %h", obs, ex); end
    end
    test_reset();
  endtask

  task automatic test_sw_timeout();
    cyc_t c; logic [W-1:0] obs, ex;
    build(OP_SW, rb(), 14);
    build(OP_SW, rb(), TO);
    halt_cycles(5);
    while (q.size() > 0) begin
      c = q.pop_front(); cycle(c, obs, ex); checks++;
      if (obs !== ex) begin errors++; $display("FAIL sw_timeout got %h exp %h", obs, ex); end
    end
    test_reset();
  endtask

  task automatic test_sw_reset();
    cyc_t c; logic [W-1:0] obs, ex;
    int nmem, cut;
    build(OP_R, 1'b0, 0);
    while (q.size() > 0) begin
      c = q.pop_front(); cycle(c, obs, ex); checks++;
      if (obs !== ex) begin errors++; $display("FAIL sw_reset_pre got %h exp %h", obs, ex); end
    end
    build(OP_SW, 1'b0, TO);
    nmem = 0;
    cut  = 0;
    foreach (q[i]) begin
      if (q[i].e.st == 3'd4) begin
        nmem++;
        if (nmem == 5) cut = i;
      end
    end
    while (q.size() > cut + 1) void'(q.pop_back());
    q[cut].rst = 1'b1;
    err_m      = 1'b0;
    need_idle  = 1'b1;
    build(OP_R, 1'b0, 0);
    while (q.size() > 0) begin
      c = q.pop_front(); cycle(c, obs, ex); checks++;
      if (obs !== ex) begin errors++; $display("FAIL sw_reset got %h exp %h", obs, ex); end
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c; logic [W-1:0] obs, ex;
    for (int i = 0; i < 17; i++) build(OP_R, rb(), 0);
    while (q.size() > 0) begin
      c = q.pop_front(); cycle(c, obs, ex); checks++;
      if (obs !== ex) begin errors++; $display("FAIL back_to_back got %h exp %h", obs, ex); end
    end
    @(negedge CLK);
    #1;
    checks++;
    if (instr_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL wrap_cnt got %0d exp 1", instr_cnt);
    end
  endtask

  task automatic test_random();
    cyc_t c; logic [W-1:0] obs, ex;
    logic [5:0] ops [5];
    int w;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 4));
      build(ops[$urandom_range(0, 4)], rb(), w);
    end
    while (q.size() > 0) begin
      c = q.pop_front(); cycle(c, obs, ex); checks++;
      if (obs !== ex) begin errors++; $display("FAIL random got %h exp %h", obs, ex); end
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    cyc_t c; logic [W-1:0] obs, ex;
    cyc_t tmp[$];
    need_idle = 1'b0;
    build(OP_R, 1'b0, 0);
    foreach (q[i]) q[i].stp = 1'b0;
    tmp = q;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      push(blank(3'd0), rop(), rb(), rb());
      q[q.size() - 1].stp = 1'b0;
    end
    push(blank(3'd0), rop(), rb(), rb());
    foreach (tmp[i]) q.push_back(tmp[i]);
    for (int i = 0; i < 4; i++) begin
      push(blank(3'd0), rop(), rb(), rb());
      q[q.size() - 1].stp = 1'b0;
    end
    while (q.size() > 0) begin
      c = q.pop_front(); cycle(c, obs, ex); checks++;
      if (obs !== ex) begin errors++; $display("FAIL step got %h exp %h", obs, ex); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_j_illegal();
    test_sw_timeout();
    test_sw_reset();
    test_reset();
    test_back_to_back();
    test_reset();
    test_random();
`ifdef SINGLE_STEP_EN
    test_reset();
    test_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
